// File: rtl/alu_mul_seq_if.sv
// Bundle of the control-path and ALU-side signals of the shift-add multiply
// sequencer. The sequencer connects through the slave modport. The master
// modport is for the surrounding CPU control path and the ALU instance.
interface alu_mul_seq_if #(
  parameter int n = 8
);

  // CPU control-path side
  logic           start;
  logic [n-1:0]   mcand;
  logic [n-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*n-1:0] product;

  // ALU control ports driven by the sequencer
  logic [n-1:0]   alu_a;
  logic [n-1:0]   alu_b;
  logic [2:0]     alu_func;
  logic [1:0]     alu_a_sel;
  logic [1:0]     alu_b_sel;
  logic [n-1:0]   alu_imm;

  // ALU results fed back to the sequencer, flags are {V,N,Z,C}
  logic [n-1:0]   alu_result;
  logic [3:0]     alu_flags;

  modport slave (
    input  start, mcand, mplier, alu_result, alu_flags,
    output busy, done, product,
           alu_a, alu_b, alu_func, alu_a_sel, alu_b_sel, alu_imm
  );

  modport master (
    output start, mcand, mplier, alu_result, alu_flags,
    input  busy, done, product,
           alu_a, alu_b, alu_func, alu_a_sel, alu_b_sel, alu_imm
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier sequencer for the picoMIPS ALU.
// It runs an 8-step shift-add multiply. Each step issues one ALU add (or a
// pass-through when the current multiplier bit is 0). The ALU result and
// carry are shifted into a {hi,lo} register pair. The ALU itself is not
// modified. This block only drives the ALU operand, function and select
// ports, and it owns them while a multiply is running.
module alu_mul_seq #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_mul_seq_if.slave bus
);

  // ALU function and operand-select encodings. These must match the alu
  // instance. Only pass-A and add are ever issued.
  localparam logic [2:0] FUNC_RA   = 3'b000;
  localparam logic [2:0] FUNC_RADD = 3'b010;
  localparam logic [1:0] SEL_REG   = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_nextState;

  // hi accumulates partial sums.
  // lo starts as the multiplier and fills with low product bits.
  logic [n-1:0]   r_hi;
  logic [n-1:0]   r_lo;
  logic [n-1:0]   r_m;
  logic [3:0]     r_cnt;
  logic [2*n-1:0] r_product;

  logic           w_c;
  logic           w_lastStep;
  logic [2*n-1:0] w_shifted;
  logic [n-1:0]   w_aluA;
  logic [n-1:0]   w_aluB;
  logic [2:0]     w_aluFunc;
  logic           w_busy;
  logic           w_done;
  logic           w_unusedFlags;

  // The carry into hi's MSB comes only from a real add. A pass step never
  // carries. hi+m always fits in n+1 bits, so no carry is ever lost.
  assign w_c           = r_lo[0] & bus.alu_flags[0];
  assign w_shifted     = {w_c, bus.alu_result, r_lo[n-1:1]};
  assign w_lastStep    = (r_cnt == 4'(n - 1));
  assign w_unusedFlags = ^bus.alu_flags[3:1];

  // State register. An asynchronous reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and ALU-control decode. The ALU sees zero operands whenever
  // no multiply step is running.
  always_comb begin
    w_nextState = r_state;
    w_aluA      = '0;
    w_aluB      = '0;
    w_aluFunc   = FUNC_RA;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        w_busy    = 1'b1;
        w_aluA    = r_hi;
        w_aluB    = r_m;
        w_aluFunc = r_lo[0] ? FUNC_RADD : FUNC_RA;
        if (w_lastStep) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath registers. Operands are captured only when a start is
  // accepted. The product register updates only on the last RUN step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_hi  <= '0;
            r_lo  <= bus.mplier;
            r_m   <= bus.mcand;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          {r_hi, r_lo} <= w_shifted;
          r_cnt        <= r_cnt + 4'd1;
          if (w_lastStep) begin
            r_product <= w_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.product   = r_product;
  assign bus.alu_a     = w_aluA;
  assign bus.alu_b     = w_aluB;
  assign bus.alu_func  = w_aluFunc;
  assign bus.alu_a_sel = SEL_REG;
  assign bus.alu_b_sel = SEL_REG;
  assign bus.alu_imm   = '0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and random checks of the shift-add multiply sequencer. The bench
// includes a small behavioural model of the picoMIPS ALU.
module tb_alu_mul_seq;

  localparam logic [2:0] FUNC_RA   = 3'b000;
  localparam logic [2:0] FUNC_RADD = 3'b010;
  localparam logic [1:0] SEL_REG   = 2'b00;

  logic clk;
  logic reset;

  alu_mul_seq_if #(.n(8)) bus ();

  alu_mul_seq #(.n(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks;
  int          errors;
  logic [15:0] prevProduct;

  logic [8:0]  aluSum;
  logic [7:0]  aluRes;
  logic        aluCarry;

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: pass A or add A+B. The carry comes from bit 8 of the
  // add result.
  always_comb begin
    aluSum   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    aluRes   = bus.alu_a;
    aluCarry = 1'b0;
    if (bus.alu_func == FUNC_RADD) begin
      aluRes   = aluSum[7:0];
      aluCarry = aluSum[8];
    end
  end

  assign bus.alu_result = aluRes;
  assign bus.alu_flags  = {1'b0, aluRes[7], (aluRes == 8'd0), aluCarry};

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands with a one-cycle start pulse. It returns at the
  // falling edge of the first RUN cycle.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.mcand  = a;
    bus.mplier = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Waits for done, with a bounded cycle budget. The cycle count is 9 for
  // the DONE cycle if the count starts at 1 in RUN1.
  task automatic waitDone(input int startCyc, output int cyc);
    cyc = startCyc;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Runs one multiply and checks the outputs cycle by cycle. It checks
  // busy, the ALU function chosen by each multiplier bit, the held product
  // and the timing of the done pulse.
  task automatic runDirected(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] expProduct);
    applyStimulus(a, b);
    for (int i = 0; i < 8; i++) begin
      checkOutput({tag, "_busy"}, 16'(bus.busy), 16'd1);
      checkOutput({tag, "_done_low"}, 16'(bus.done), 16'd0);
      checkOutput({tag, "_func"}, 16'(bus.alu_func), b[i] ? 16'(FUNC_RADD) : 16'(FUNC_RA));
      checkOutput({tag, "_alu_b"}, 16'(bus.alu_b), 16'(a));
      checkOutput({tag, "_sel"}, 16'({bus.alu_a_sel, bus.alu_b_sel}), 16'({SEL_REG, SEL_REG}));
      checkOutput({tag, "_imm"}, 16'(bus.alu_imm), 16'd0);
      checkOutput({tag, "_held"}, bus.product, prevProduct);
      if (i == 0) begin
        checkOutput({tag, "_alu_a_first"}, 16'(bus.alu_a), 16'd0);
      end
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, 16'(bus.done), 16'd1);
    checkOutput({tag, "_busy_done"}, 16'(bus.busy), 16'd1);
    checkOutput({tag, "_product"}, bus.product, expProduct);
    @(negedge clk);
    checkOutput({tag, "_done_after"}, 16'(bus.done), 16'd0);
    checkOutput({tag, "_busy_after"}, 16'(bus.busy), 16'd0);
    checkOutput({tag, "_product_after"}, bus.product, expProduct);
    prevProduct = expProduct;
  endtask

  // Directed sequence, then the random scoreboard
  initial begin
    int          cyc;
    int          doneCount;
    int          opIdx;
    int          lastDone;
    logic [7:0]  opA [3];
    logic [7:0]  opB [3];
    logic [15:0] expHeld;
    logic [7:0]  ra;
    logic [7:0]  rb;

    checks      = 0;
    errors      = 0;
    prevProduct = 16'h0000;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mcand   = 8'd0;
    bus.mplier  = 8'd0;

    #1;
    $display("[TB] reset state");
    checkOutput("rst_busy", 16'(bus.busy), 16'd0);
    checkOutput("rst_done", 16'(bus.done), 16'd0);
    checkOutput("rst_product", bus.product, 16'h0000);
    checkOutput("rst_func", 16'(bus.alu_func), 16'(FUNC_RA));
    checkOutput("rst_alu_a", 16'(bus.alu_a), 16'd0);
    checkOutput("rst_alu_b", 16'(bus.alu_b), 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", 16'(bus.busy), 16'd0);

    $display("[TB] basic multiplies");
    runDirected("mul_13x11", 8'd13, 8'd11, 16'h008F);
    runDirected("mul_ffxff", 8'hFF, 8'hFF, 16'hFE01);
    runDirected("mul_80x02", 8'h80, 8'h02, 16'h0100);
    runDirected("mul_5ax00", 8'h5A, 8'h00, 16'h0000);

    $display("[TB] start during RUN is dropped");
    applyStimulus(8'd6, 8'd7);
    @(negedge clk);
    @(negedge clk);
    bus.mcand  = 8'd9;
    bus.mplier = 8'd9;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    waitDone(4, cyc);
    checkOutput("drop_latency", 16'(cyc), 16'd9);
    checkOutput("drop_product", bus.product, 16'h002A);
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    checkOutput("drop_no_second_done", 16'(doneCount), 16'd0);
    checkOutput("drop_idle", 16'(bus.busy), 16'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(8'd50, 8'd3);
    for (int i = 0; i < 4; i++) @(negedge clk);
    checkOutput("abort_busy_before", 16'(bus.busy), 16'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 16'(bus.busy), 16'd0);
    checkOutput("abort_done", 16'(bus.done), 16'd0);
    checkOutput("abort_product", bus.product, 16'h0000);
    #1 reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    checkOutput("abort_no_done", 16'(doneCount), 16'd0);
    checkOutput("abort_product_held", bus.product, 16'h0000);
    prevProduct = 16'h0000;
    runDirected("mul_3x7", 8'd3, 8'd7, 16'h0015);

    $display("[TB] start held high");
    opA[0] = 8'd3;   opB[0] = 8'd5;
    opA[1] = 8'd200; opB[1] = 8'd100;
    opA[2] = 8'd17;  opB[2] = 8'd15;
    @(negedge clk);
    bus.mcand  = opA[0];
    bus.mplier = opB[0];
    bus.start  = 1'b1;
    opIdx    = 0;
    lastDone = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c < 9)       expHeld = 16'h0015;
      else if (c < 19) expHeld = 16'h000F;
      else if (c < 29) expHeld = 16'h4E20;
      else             expHeld = 16'h00FF;
      checkOutput("held_done", 16'(bus.done), 16'((c % 10) == 9));
      checkOutput("held_product", bus.product, expHeld);
      if (bus.done) begin
        if (lastDone >= 0) begin
          checkOutput("held_interval", 16'(c - lastDone), 16'd10);
        end
        lastDone = c;
        opIdx++;
        if (opIdx < 3) begin
          bus.mcand  = opA[opIdx];
          bus.mplier = opB[opIdx];
        end
      end
    end
    bus.start = 1'b0;
    checkOutput("held_op_count", 16'(opIdx), 16'd3);

    $display("[TB] random scoreboard");
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb);
      waitDone(1, cyc);
      checkOutput("rand_product", bus.product, 16'(ra) * 16'(rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
